// File: rtl/uart_rx_buffer_if.sv
// Receive-buffer bus: UART receiver strobe, consumer read handshake and status.
interface uart_rx_buffer_if #(
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic          rxDone;
    logic [7:0]    rxData;
    logic          rxError;
    logic          dataRead;
    logic          clearFlags;
    logic [7:0]    dataOut;
    logic          dataValid;
    logic [CW-1:0] count;
    logic          bufFull;
    logic          overrun;
    logic          frameErr;

    modport master (
        output rxDone, rxData, rxError, dataRead, clearFlags,
        input  dataOut, dataValid, count, bufFull, overrun, frameErr
    );

    modport slave (
        input  rxDone, rxData, rxError, dataRead, clearFlags,
        output dataOut, dataValid, count, bufFull, overrun, frameErr
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: circular RAM FIFO feeding a registered output stage,
// with sticky overrun and framing-error flags.
module uart_rx_buffer #(
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_ram [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [7:0]    r_data;
    logic          r_valid;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_ov;
    logic          r_fe;

    logic          w_accept;
    logic          w_drop;
    logic          w_err;
    logic          w_pop;
    logic          w_ram_avail;
    logic          w_load;
    logic [CW-1:0] w_count_nxt;

    // Output register is always refilled whenever the RAM holds data, so the
    // RAM never holds more than DEPTH-1 bytes and wp != rp means non-empty.
    assign w_ram_avail = (r_wp != r_rp);
    assign w_accept    = bus.rxDone & ~bus.rxError & ~r_full;
    assign w_drop      = bus.rxDone & ~bus.rxError &  r_full;
    assign w_err       = bus.rxDone &  bus.rxError;
    assign w_pop       = bus.dataRead & r_valid;
    assign w_load      = (~r_valid | w_pop) & w_ram_avail;

    // Occupancy after this edge: accept and pop in the same cycle cancel.
    always_comb begin
        w_count_nxt = r_count;
        if (w_accept && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_accept && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Byte storage; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ram[r_wp] <= bus.rxData;
        end
    end

    // Pointers, output stage and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_load) begin
                r_data  <= r_ram[r_rp];
                r_valid <= 1'b1;
                r_rp    <= r_rp + AW'(1);
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Sticky error flags; a new event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ov <= 1'b0;
            r_fe <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ov <= 1'b1;
            end else if (bus.clearFlags) begin
                r_ov <= 1'b0;
            end
            if (w_err) begin
                r_fe <= 1'b1;
            end else if (bus.clearFlags) begin
                r_fe <= 1'b0;
            end
        end
    end

    assign bus.dataOut   = r_data;
    assign bus.dataValid = r_valid;
    assign bus.count     = r_count;
    assign bus.bufFull   = r_full;
    assign bus.overrun   = r_ov;
    assign bus.frameErr  = r_fe;
endmodule
